fpu_mul_post_norm: RTL and testbench

- Single-precision FP multiply back end for the OR1200 FPU.
- Drives the 24x24 unsigned mantissa multiplier (fixed `MUL_LAT`-cycle pipeline, no reset, no valid) with hidden-bit mantissas.
- Carries sign, exponent, class and rounding mode alongside the multiplier in a matching delay line, then consumes the 48-bit product.
- Normalizes, rounds, handles IEEE-754 specials, and emits a registered 32-bit result with a one-cycle `ready_o` strobe and exception flags; fully pipelined, one operation per cycle.

---
 rtl/fpu_mul_post_norm.sv | 240 ++++++++++++++++++++++++
 tb/tb_fpu_mul_post_norm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_post_norm.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_post_norm
// Purpose  : Single-precision multiply back end for the OR1200 FPU.
//            It classifies the operands and feeds hidden-bit mantissas to an
//            external fixed-latency 24x24 multiplier. Sign, exponent sum,
//            operand class and rounding mode travel down a matching delay
//            line. When the product arrives it is normalized, rounded and
//            checked for IEEE-754 special cases, and the result is
//            registered with a one-cycle ready strobe.
// Ports    : clk, rst_n (async, active low)
//            start_i, opa_i[31:0], opb_i[31:0], rmode_i[1:0] : operation in
//            fracta_o[23:0], fractb_o[23:0]  : mantissas to the multiplier
//            product_i[47:0]                 : product, MUL_LAT edges later
//            output_o[31:0], ready_o, overflow_o, underflow_o, inexact_o,
//            invalid_o                       : registered result and flags
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_post_norm #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic [1:0]  rmode_i,
   output logic [23:0] fracta_o,
   output logic [23:0] fractb_o,
   input  logic [47:0] product_i,
   output logic [31:0] output_o,
   output logic        ready_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic        inexact_o,
   output logic        invalid_o
);

   localparam logic [1:0]  c_rm_rne = 2'b00;
   localparam logic [1:0]  c_rm_rz  = 2'b01;
   localparam logic [1:0]  c_rm_rup = 2'b10;
   localparam logic [1:0]  c_rm_rdn = 2'b11;
   localparam logic [31:0] c_qnan   = 32'h7FC0_0000;

   // Everything the back end needs about an operation, minus the product.
   typedef struct packed {
      logic       valid;
      logic       sign;
      logic [9:0] esum;    // signed ea+eb-127
      logic       a_zero;
      logic       a_inf;
      logic       a_nan;
      logic       b_zero;
      logic       b_inf;
      logic       b_nan;
      logic [1:0] rmode;
   } side_t;

   // ---------------------------------------------------------------- front
   logic [7:0]  w_ea, w_eb;
   logic [22:0] w_fa, w_fb;
   logic        w_a_zero, w_a_max, w_b_zero, w_b_max;
   logic [9:0]  w_esum;

   assign w_ea     = opa_i[30:23];
   assign w_eb     = opb_i[30:23];
   assign w_fa     = opa_i[22:0];
   assign w_fb     = opb_i[22:0];
   assign w_a_zero = (w_ea == 8'h00);
   assign w_b_zero = (w_eb == 8'h00);
   assign w_a_max  = (w_ea == 8'hFF);
   assign w_b_max  = (w_eb == 8'hFF);
   assign w_esum   = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127;

   // Non-normal operands present a zero mantissa; their result is decided
   // entirely by the special-case logic, so the product is don't-care.
   assign fracta_o = (!w_a_zero && !w_a_max) ? {1'b1, w_fa} : 24'd0;
   assign fractb_o = (!w_b_zero && !w_b_max) ? {1'b1, w_fb} : 24'd0;

   // ----------------------------------------------------------- delay line
   side_t pipe_q [MUL_LAT];
   side_t pipe_d [MUL_LAT];

   always_comb begin
      pipe_d[0].valid  = start_i;
      pipe_d[0].sign   = opa_i[31] ^ opb_i[31];
      pipe_d[0].esum   = w_esum;
      pipe_d[0].a_zero = w_a_zero;
      pipe_d[0].a_inf  = w_a_max & ~|w_fa;
      pipe_d[0].a_nan  = w_a_max & |w_fa;
      pipe_d[0].b_zero = w_b_zero;
      pipe_d[0].b_inf  = w_b_max & ~|w_fb;
      pipe_d[0].b_nan  = w_b_max & |w_fb;
      pipe_d[0].rmode  = rmode_i;
      for (int i = 1; i < MUL_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MUL_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   // ------------------------------------------------------------- back end
   side_t              w_slot;
   logic [23:0]        w_m;
   logic               w_g, w_s, w_inc;
   logic signed [9:0]  w_e_norm, w_e_fin;
   logic [24:0]        w_m_sum;
   logic [22:0]        w_frac_fin;
   logic [31:0]        w_res;
   logic               w_ovf, w_unf, w_inx, w_inv;

   assign w_slot = pipe_q[MUL_LAT-1];

   always_comb begin
      // Normalize: the product of two [1,2) mantissas lies in [1,4).
      if (product_i[47]) begin
         w_m      = product_i[47:24];
         w_g      = product_i[23];
         w_s      = |product_i[22:0];
         w_e_norm = $signed(w_slot.esum) + 10'sd1;
      end else begin
         w_m      = product_i[46:23];
         w_g      = product_i[22];
         w_s      = |product_i[21:0];
         w_e_norm = $signed(w_slot.esum);
      end

      case (w_slot.rmode)
         c_rm_rne: w_inc = w_g & (w_s | w_m[0]);
         c_rm_rz:  w_inc = 1'b0;
         c_rm_rup: w_inc = ~w_slot.sign & (w_g | w_s);
         default:  w_inc = w_slot.sign & (w_g | w_s);
      endcase

      // A carry out of the mantissa only happens from all-ones, so the
      // rounded value is exactly 1.0 at the next exponent.
      w_m_sum = {1'b0, w_m} + {24'd0, w_inc};
      if (w_m_sum[24]) begin
         w_frac_fin = 23'd0;
         w_e_fin    = w_e_norm + 10'sd1;
      end else begin
         w_frac_fin = w_m_sum[22:0];
         w_e_fin    = w_e_norm;
      end

      w_res = {w_slot.sign, w_e_fin[7:0], w_frac_fin};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_inx = w_g | w_s;
      w_inv = 1'b0;

      if (w_slot.a_nan || w_slot.b_nan) begin
         w_res = c_qnan;
         w_inx = 1'b0;
      end else if ((w_slot.a_inf && w_slot.b_zero) ||
                   (w_slot.a_zero && w_slot.b_inf)) begin
         w_res = c_qnan;
         w_inx = 1'b0;
         w_inv = 1'b1;
      end else if (w_slot.a_inf || w_slot.b_inf) begin
         w_res = {w_slot.sign, 8'hFF, 23'd0};
         w_inx = 1'b0;
      end else if (w_slot.a_zero || w_slot.b_zero) begin
         w_res = {w_slot.sign, 31'd0};
         w_inx = 1'b0;
      end else if (w_e_fin >= 10'sd255) begin
         w_ovf = 1'b1;
         w_inx = 1'b1;
         // Directed modes saturate to max finite when rounding away from inf.
         case (w_slot.rmode)
            c_rm_rne: w_res = {w_slot.sign, 8'hFF, 23'd0};
            c_rm_rz:  w_res = {w_slot.sign, 31'h7F7F_FFFF};
            c_rm_rup: w_res = w_slot.sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
            default:  w_res = w_slot.sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
         endcase
      end else if (w_e_fin <= 10'sd0) begin
         w_res = {w_slot.sign, 31'd0};
         w_unf = 1'b1;
         w_inx = 1'b1;
      end
   end

   // ------------------------------------------------------ output register
   logic [31:0] output_q, output_d;
   logic        ready_q, ready_d;
   logic        ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, inv_q, inv_d;

   always_comb begin
      ready_d  = w_slot.valid;
      output_d = output_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      inv_d    = inv_q;
      if (w_slot.valid) begin
         output_d = w_res;
         ovf_d    = w_ovf;
         unf_d    = w_unf;
         inx_d    = w_inx;
         inv_d    = w_inv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_q <= 32'd0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         output_q <= output_d;
         ready_q  <= ready_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
         inv_q    <= inv_d;
      end
   end

   assign output_o    = output_q;
   assign ready_o     = ready_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
   assign inexact_o   = inx_q;
   assign invalid_o   = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_post_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mul_post_norm
// Purpose  : Self-checking bench for fpu_mul_post_norm. Provides a
//            MUL_LAT-deep mantissa multiplier, applies directed and random
//            operations and compares every cycle's outputs with an
//            exact-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_post_norm;

   localparam int MUL_LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] opa = '0, opb = '0;
   logic [1:0]  rmode = '0;
   logic [23:0] fracta, fractb;
   logic [47:0] product;
   logic [31:0] result;
   logic        ready, ovf, unf, inx, inv;

   always #5 clk = ~clk;

   fpu_mul_post_norm #(.MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .opa_i      (opa),
      .opb_i      (opb),
      .rmode_i    (rmode),
      .fracta_o   (fracta),
      .fractb_o   (fractb),
      .product_i  (product),
      .output_o   (result),
      .ready_o    (ready),
      .overflow_o (ovf),
      .underflow_o(unf),
      .inexact_o  (inx),
      .invalid_o  (inv)
   );

   // Unreset multiplier pipeline
   logic [47:0] mul_pipe [MUL_LAT];
   always @(posedge clk) begin
      mul_pipe[0] <= {24'd0, fracta} * {24'd0, fractb};
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
   end
   assign product = mul_pipe[MUL_LAT-1];

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;   // {overflow, underflow, inexact, invalid}
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;
   logic [3:0]  last_flg = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   function automatic logic [23:0] ref_frac(input logic [31:0] op);
      if (op[30:23] != 8'h00 && op[30:23] != 8'hFF) return {1'b1, op[22:0]};
      return 24'd0;
   endfunction

   // Reference: exact integer product, rounded by comparing the discarded
   // remainder with one half-ulp.
   function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
      exp_t        r;
      int          ea = int'(a[30:23]);
      int          eb = int'(b[30:23]);
      logic        sg = a[31] ^ b[31];
      logic        an = (ea == 255) && (a[22:0] != 0);
      logic        bn = (eb == 255) && (b[22:0] != 0);
      logic        ai = (ea == 255) && (a[22:0] == 0);
      logic        bi = (eb == 255) && (b[22:0] == 0);
      logic        az = (ea == 0);
      logic        bz = (eb == 0);
      logic [63:0] p, kept, rem, half;
      int          n, sh;
      longint      v, ef;
      logic        up, found;
      r.due = 0;
      r.flg = 4'b0000;
      if (an || bn) begin
         r.res = 32'h7FC00000;
      end else if ((ai && bz) || (az && bi)) begin
         r.res = 32'h7FC00000;
         r.flg = 4'b0001;
      end else if (ai || bi) begin
         r.res = {sg, 8'hFF, 23'd0};
      end else if (az || bz) begin
         r.res = {sg, 31'd0};
      end else begin
         p = {40'd1, a[22:0]} * 0;
         p = {41'd1, a[22:0]} * {41'd1, b[22:0]};
         n = 0;
         found = 1'b0;
         for (int i = 63; i >= 0; i--) begin
            if (!found && p[i]) begin
               n = i;
               found = 1'b1;
            end
         end
         sh   = n - 23;
         kept = p >> sh;
         rem  = p & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         case (rm)
            2'b00:   up = (rem > half) || (rem == half && kept[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !sg && (rem != 0);
            default: up = sg && (rem != 0);
         endcase
         v  = longint'(ea + eb - 127 + (n - 46)) * 64'sd8388608
              + longint'(kept) - 64'sd8388608 + (up ? 64'sd1 : 64'sd0);
         ef = v >>> 23;
         if (ef >= 255) begin
            r.flg = 4'b1010;
            case (rm)
               2'b00:   r.res = {sg, 31'h7F800000};
               2'b01:   r.res = {sg, 31'h7F7FFFFF};
               2'b10:   r.res = sg ? 32'hFF7FFFFF : 32'h7F800000;
               default: r.res = sg ? 32'hFF800000 : 32'h7F7FFFFF;
            endcase
         end else if (ef <= 0) begin
            r.res = {sg, 31'd0};
            r.flg = 4'b0110;
         end else begin
            r.res = {sg, v[30:0]};
            r.flg = {2'b00, rem != 0, 1'b0};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] gen_op();
      logic [7:0]  e;
      logic [22:0] f = 23'($urandom);
      case ($urandom_range(0, 11))
         0:       e = 8'h00;
         1: begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = 23'd0; end
         2:       e = 8'($urandom_range(230, 254));
         3:       e = 8'($urandom_range(1, 30));
         4:       e = 8'($urandom_range(60, 66));
         5: begin e = 8'($urandom_range(100, 154)); f = '1; end
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, f};
   endfunction

   task automatic check_outputs();
      exp_t e;
      logic [31:0] flags = {28'd0, ovf, unf, inx, inv};
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         chk("ready", {31'd0, ready}, 32'd1);
         chk("result", result, e.res);
         chk("flags", flags, {28'd0, e.flg});
         last_res = e.res;
         last_flg = e.flg;
      end else begin
         chk("ready_idle", {31'd0, ready}, 32'd0);
         chk("hold_result", result, last_res);
         chk("hold_flags", flags, {28'd0, last_flg});
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      chk("fracta", {8'd0, fracta}, {8'd0, ref_frac(opa)});
      chk("fractb", {8'd0, fractb}, {8'd0, ref_frac(opb)});
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
   endtask

   task automatic op_fixed(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                           input logic [31:0] res, input logic [3:0] flg);
      exp_t e;
      start = 1'b1; opa = a; opb = b; rmode = rm;
      e.res = res; e.flg = flg; e.due = cyc + MUL_LAT + 1;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic op_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
      exp_t e;
      start = 1'b1; opa = a; opb = b; rmode = rm;
      e = ref_mul(a, b, rm);
      e.due = cyc + MUL_LAT + 1;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset_result", result, 32'd0);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_flags", {28'd0, ovf, unf, inx, inv}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      idle(2);

      // Basic and back-to-back
      op_fixed(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);
      idle(6);
      op_fixed(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);
      op_fixed(32'hC0400000, 32'h3F000000, 2'b00, 32'hBFC00000, 4'b0000);
      idle(6);
      // Rounding modes
      op_fixed(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, 32'h407FFFFE, 4'b0010);
      op_fixed(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b01, 32'h407FFFFE, 4'b0010);
      op_fixed(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, 32'h407FFFFF, 4'b0010);
      op_fixed(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b11, 32'h407FFFFE, 4'b0010);
      // Overflow, underflow, specials
      op_fixed(32'h7F000000, 32'h40000000, 2'b00, 32'h7F800000, 4'b1010);
      op_fixed(32'h7F000000, 32'h40000000, 2'b01, 32'h7F7FFFFF, 4'b1010);
      op_fixed(32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0110);
      op_fixed(32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b0001);
      op_fixed(32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000);
      idle(6);

      // Randomized traffic against the reference model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 9) < 7) op_model(gen_op(), gen_op(), 2'($urandom));
         else begin
            opa = gen_op();
            opb = gen_op();
            tick();
         end
      end
      idle(6);

      // Reset while an operation is in flight
      op_model(32'h3FC00000, 32'h40000000, 2'b00);   // cycle c0
      idle(1);                                        // cycle c0+1
      rst_n = 1'b0;                                   // cycle c0+2
      #1;
      chk("midreset_result", result, 32'd0);
      chk("midreset_ready", {31'd0, ready}, 32'd0);
      chk("midreset_flags", {28'd0, ovf, unf, inx, inv}, 32'd0);
      sb_q.delete();
      last_res = '0;
      last_flg = '0;
      idle(1);
      rst_n = 1'b1;                                   // cycle c0+3
      idle(8);                                        // through c0+10

      op_model(32'hC0400000, 32'h3F000000, 2'b00);
      idle(6);
      chk("drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
